// File: rtl/channel_pkg.sv
// -----------------------------------------------------------------------------
// channel_pkg
// Shared definitions for the multi-lane blocking_channel:
//   channel_mode_e : selects the full-lane policy (back-pressure or drop).
//   count_width()  : width of an occupancy counter that must represent 0..depth.
//   is_pow2()      : used to validate the FIFO depth at elaboration.
// -----------------------------------------------------------------------------
package channel_pkg;

   typedef enum logic {
      CH_MODE_BLOCKING    = 1'b0,  // full lane deasserts in_ready
      CH_MODE_NONBLOCKING = 1'b1   // full lane keeps in_ready, drops and flags
   } channel_mode_e;

   // Occupancy spans 0..depth inclusive, so one bit more than the pointer.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/channel_fifo_lane.sv
// -----------------------------------------------------------------------------
// channel_fifo_lane
// One lane of the channel: a DEPTH-entry circular buffer with ready/valid on
// both sides. In blocking mode a full lane deasserts in_ready; in non-blocking
// mode in_ready stays high and a word arriving at a full lane with no pop is
// dropped, setting the sticky overflow flag.
//
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   in_data/valid/ready   : producer side
//   out_data/valid/ready  : consumer side; out_data is 0 while out_valid is 0
//   count                 : occupancy, 0..DEPTH
//   overflow              : sticky drop flag (non-blocking mode only)
// All outputs are registers or decoded from registers only.
// -----------------------------------------------------------------------------
module channel_fifo_lane
   import channel_pkg::*;
#(
   parameter int            WIDTH = 8,
   parameter int            DEPTH = 4,
   parameter channel_mode_e MODE  = CH_MODE_BLOCKING,
   localparam int           PW    = $clog2(DEPTH),
   localparam int           CW    = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    count,
   output logic             overflow
);

   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $fatal(1, "channel_fifo_lane: DEPTH must be a power of two and >= 2");
   end

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             live;       // high from the first edge after reset release
   logic             full;
   logic             push;
   logic             pop;
   logic             drop;
   logic [CW-1:0]    count_next;

   assign full      = (count == FULL_COUNT);
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   // in_ready depends only on registers: a pop on a full blocking lane does
   // not reopen the input until the following cycle.
   assign in_ready  = (MODE == CH_MODE_BLOCKING) ? (live && !full) : live;

   // NOTE: every signal assigned here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      push       = 1'b0;
      drop       = 1'b0;
      count_next = count;
      pop        = out_valid && out_ready;
      if (in_valid && in_ready) begin
         // A full non-blocking lane accepts only if the head leaves this edge.
         if (!full || pop) begin
            push = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
      if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         live     <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         live  <= 1'b1;
         count <= count_next;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);  // DEPTH is a power of two: wraps naturally
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // NOTE: the buffer is deliberately not reset; stale entries are hidden by
   // the out_valid mask on out_data, and leaving it reset-free keeps it RAM-friendly.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

endmodule

// File: rtl/blocking_channel.sv
// -----------------------------------------------------------------------------
// blocking_channel
// Multi-lane point-to-point channel between decoder processing units. Each of
// the CHANNELS lanes is an independent channel_fifo_lane; lanes share only
// clk and reset. Lane i occupies slice [i*WIDTH +: WIDTH] of the data buses
// and [i*CW +: CW] of count, where CW = $clog2(DEPTH)+1.
//
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   in_data/valid/ready   : producer side, one bit of valid/ready per lane
//   out_data/valid/ready  : consumer side, one bit of valid/ready per lane
//   count                 : per-lane occupancy
//   overflow              : per-lane sticky drop flag (0 in blocking mode)
// -----------------------------------------------------------------------------
module blocking_channel
   import channel_pkg::*;
#(
   parameter int            WIDTH    = 8,
   parameter int            DEPTH    = 4,
   parameter int            CHANNELS = 1,
   parameter channel_mode_e MODE     = CH_MODE_BLOCKING,
   localparam int           CW       = count_width(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*CW-1:0]    count,
   output logic [CHANNELS-1:0]       overflow
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      channel_fifo_lane #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .MODE  (MODE)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .in_data   (in_data[i*WIDTH +: WIDTH]),
         .in_valid  (in_valid[i]),
         .in_ready  (in_ready[i]),
         .out_data  (out_data[i*WIDTH +: WIDTH]),
         .out_valid (out_valid[i]),
         .out_ready (out_ready[i]),
         .count     (count[i*CW +: CW]),
         .overflow  (overflow[i])
      );
   end

endmodule

// File: doc/blocking_channel.md
# blocking_channel

Parametrised multi-lane point-to-point channel between decoder processing units. It generalises the single-register non-blocking channel with three additions: a per-lane FIFO of configurable depth, a ready/valid handshake on both sides, and a compile-time mode. The mode selects either back-pressure (blocking) or drop-on-full (non-blocking) with a sticky overflow flag. All lanes share one clock and reset, but are otherwise independent.

## Interface
- `WIDTH`, default 8: payload bits per lane.
- `DEPTH`, default 4: FIFO entries per lane. Must be a power of two and ≥ 2.
- `CHANNELS`, default 1: number of independent lanes.
- `MODE`, default `CH_MODE_BLOCKING`: `CH_MODE_BLOCKING` or `CH_MODE_NONBLOCKING`.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low. Asserted when 0.
- `in_data`, input, CHANNELS*WIDTH: lane i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`, input, CHANNELS: producer offers a word.
- `in_ready`, output, CHANNELS: lane accepts a word this cycle.
- `out_data`, output, CHANNELS*WIDTH: head word of each lane. Forced to 0 when that lane's `out_valid` is 0.
- `out_valid`, output, CHANNELS: lane holds at least 1 word.
- `out_ready`, input, CHANNELS: consumer takes the head word.
- `count`, output, CHANNELS*(CW), where CW = $clog2(DEPTH)+1: occupancy per lane, 0..DEPTH.
- `overflow`, output, CHANNELS: sticky flag, set when a word is dropped. Always 0 in blocking mode.

## Operation
- **Push and pop:** push on a lane when `in_valid & in_ready` at a rising edge. Pop when `out_valid & out_ready` at a rising edge.
- **Storage:** per lane, a circular buffer of DEPTH entries.
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is held in a separate register.
- **Occupancy:** `count` is incremented on push only, decremented on pop only, and unchanged on push+pop or on idle.
- **Blocking mode:**
  - `in_ready = (count != DEPTH)`, decoded from registers only. There is no combinational path from `out_ready`.
  - When the lane is full, a simultaneous pop does not open `in_ready` in the same cycle.
- **Non-blocking mode:**
  - `in_ready` = 1 whenever reset is deasserted.
  - Full, `in_valid`=1, no pop: the incoming word is dropped. The oldest data is kept, `overflow` is set, and `count` stays DEPTH.
  - Full, `in_valid`=1, pop: the word is accepted, the head advances, and `count` stays DEPTH.
- **Outputs:** `out_valid = (count != 0)`. `out_data` = buffer entry at the read pointer, AND-masked by `out_valid`.
- **Lane independence:** no cross-lane interaction of any kind.
- **Reset asserted (asynchronous, any cycle, including mid-transfer):**
  - Pointers and `count` go to 0; `overflow` goes to 0.
  - `out_valid`=0, `out_data`=0, `in_ready`=0.
  - Buffer contents are not cleared; the masked `out_data` makes them invisible.
- **Reset released:** synchronous deassertion is the system's responsibility. On the first edge after release, blocking-mode `in_ready` = 1.

## Timing
- **Latency:** 1 cycle. A word pushed at edge N has `out_valid`=1 and `out_data` = that word after edge N. This matches the existing non-blocking channel when `out_ready` is held at 1.
- **Throughput:** 1 word/cycle/lane sustained with `out_ready`=1. Empty-lane push followed by the next-edge pop never stalls.
- **Outputs are registered or decoded from registers:** `in_ready`, `out_valid`, `out_data`, `count`, `overflow`. The only input-to-output path is none.
- **Wrap-around:** the pointer increments from DEPTH-1 to 0. The bench must cover pushing and popping across the boundary.
- **Push on an empty lane:** the word appears on the output after the edge. It cannot be popped in the same edge, because `out_valid` was 0.

## Structure
- **Shared package `channel_pkg`:**
  - `channel_mode_e` enum: `CH_MODE_BLOCKING`, `CH_MODE_NONBLOCKING`.
  - A width helper function for `count`.
- **Sub-module `channel_fifo_lane`:** single lane, parameters `WIDTH`, `DEPTH`, `MODE`. The top generates CHANNELS instances and slices the packed buses.
- **Assertions:** elaboration-time assertion that DEPTH is a power of two ≥ 2.

## Test plan
1. **Reset and single word.** Hold reset=0 for 10 cycles, then check `out_valid`=0, `in_ready`=0, `count`=0. Release reset, then push 8'hAA with `out_ready`=1. After 1 edge: `out_valid`=1, `out_data`=8'hAA. The next idle edge gives `out_valid`=0 and `out_data`=0.
2. **Streaming.** Push 8'hAA, 8'hF0, 8'h55 back-to-back; a gap; then 8'h55 again. The output reproduces the input sequence delayed by 1 cycle, with `out_valid` low in the gap cycle.
3. **Blocking full.** Settings: DEPTH=4, `out_ready`=0. Push 1, 2, 3, 4 → `count`=4, `in_ready`=0. Hold 5 offered for 3 cycles → no change, `overflow`=0. Raise `out_ready` → pops 1, 2, 3, 4 in order, then 5 once accepted.
4. **Non-blocking drop.** Settings: DEPTH=4, `out_ready`=0. Push 1..6 → `count`=4, `overflow`=1. Then drain → 1, 2, 3, 4. `overflow` stays 1 until reset.
5. **Wrap plus simultaneous push/pop.** Stream 20 words with `out_ready` toggling 1,0,1,1. Check data order, that `count` never exceeds 4, and push+pop on a full lane in non-blocking mode with `count` holding at 4.
6. **Multi-lane and mid-reset.** Settings: CHANNELS=3. Lane 1 is stalled while lanes 0 and 2 stream, and they are unaffected. Assert reset mid-burst between clock edges → all outputs clear immediately, before the next edge.
